// File: rtl/sub4bit_serial.sv
// Bit-serial 4-bit subtractor: D = A - B - bin (mod 16), bout = borrow out.
// Operands are latched on an accepted start and consumed LSB first, one bit
// per clock. The result register only updates when the last bit is processed,
// so D/bout never expose a partially assembled difference.
module sub4bit_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       bin,
    input  logic       start,
    output logic [3:0] D,
    output logic       bout,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic [3:0] sa;     // minuend shift register, current bit at [0]
    logic [3:0] sb;     // subtrahend shift register, current bit at [0]
    logic [2:0] res;    // difference bits 0..2, shifted in from the top
    logic       br;     // running borrow
    logic [1:0] cnt;    // index of the bit being processed

    logic a_bit, b_bit, d_bit, br_nxt;

    // One full-subtractor cell applied to the current bit pair
    always_comb begin
        a_bit  = sa[0];
        b_bit  = sb[0];
        d_bit  = a_bit ^ b_bit ^ br;
        br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    end

    // Control FSM and serial datapath; reset clears everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= 4'd0;
            sb    <= 4'd0;
            res   <= 3'd0;
            br    <= 1'b0;
            cnt   <= 2'd0;
            D     <= 4'd0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= A;
                        sb    <= B;
                        br    <= bin;
                        cnt   <= 2'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa  <= {1'b0, sa[3:1]};
                    sb  <= {1'b0, sb[3:1]};
                    br  <= br_nxt;
                    res <= {d_bit, res[2:1]};
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        // Bit 3 completes the word; publish it in one shot
                        D     <= {d_bit, res};
                        bout  <= br_nxt;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status flags decode straight from state so reset clears them at once
    always_comb begin
        busy = (state == RUN) || (state == DONE);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_sub4bit_serial.sv
// Directed self-checking bench for sub4bit_serial.
module tb_sub4bit_serial;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       bin;
    logic       start;
    logic [3:0] D;
    logic       bout;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    sub4bit_serial dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .bin   (bin),
        .start (start),
        .D     (D),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: 5-bit difference, top bit is the borrow
    function automatic logic [4:0] ref_sub(input logic [3:0] a, input logic [3:0] b, input logic bi);
        ref_sub = {1'b0, a} - {1'b0, b} - {4'd0, bi};
    endfunction

    function automatic logic [3:0] opa(input int i);
        opa = 4'((i * 7 + 3) % 16);
    endfunction
    function automatic logic [3:0] opb(input int i);
        opb = 4'((i * 5 + 1) % 16);
    endfunction
    function automatic logic opc(input int i);
        opc = 1'(i % 2);
    endfunction

    // Run one operation from IDLE; releases rst on the same cycle as start.
    // Operands are scrambled right after acceptance.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                         output logic [3:0] d, output logic bo, output int lat,
                         output int bcnt, output logic post_busy, output logic post_done);
        @(negedge clk);
        rst = 1'b0; A = a; B = b; bin = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = ~a; B = ~b; bin = ~bi;
        lat  = 1;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 12) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
        d  = D;
        bo = bout;
        @(posedge clk); #1;
        post_busy = busy;
        post_done = done;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; A = 4'hF; B = 4'h0; bin = 1'b0;
        #2;
        if ({D, bout, busy, done} !== 7'd0) begin
            n_err++; $display("FAIL reset_state: got D=%h bout=%b busy=%b done=%b, want all 0", D, bout, busy, done);
        end
        n_cmp++;
    endtask

    task automatic test_vectors;
        logic [3:0] va [5] = '{4'd9, 4'd3, 4'd0, 4'd15, 4'd15};
        logic [3:0] vb [5] = '{4'd3, 4'd9, 4'd0, 4'd15, 4'd0};
        logic       vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0] ed [5] = '{4'd6, 4'hA, 4'd15, 4'd0, 4'd14};
        logic       eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] d; logic bo, pb, pd; int lat, bc;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vc[i], d, bo, lat, bc, pb, pd);
            if (d !== ed[i] || bo !== eb[i]) begin
                n_err++; $display("FAIL vec%0d_result: got D=%h bout=%b, want D=%h bout=%b", i, d, bo, ed[i], eb[i]);
            end
            n_cmp++;
            if (lat !== 5) begin
                n_err++; $display("FAIL vec%0d_latency: got %0d edges, want 5", i, lat);
            end
            n_cmp++;
            if (bc !== 5 || pb !== 1'b0) begin
                n_err++; $display("FAIL vec%0d_busy: got %0d busy cycles, busy after=%b, want 5 and 0", i, bc, pb);
            end
            n_cmp++;
            if (pd !== 1'b0) begin
                n_err++; $display("FAIL vec%0d_done_width: got done=%b in cycle after strobe, want 0", i, pd);
            end
            n_cmp++;
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] d, pd_d; logic bo, pb, pd, pd_b; int lat, bc;
        logic [4:0] r;
        do_op(4'd7, 4'd2, 1'b0, d, bo, lat, bc, pb, pd);
        pd_d = 4'd5; pd_b = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            A = opa(i); B = opb(i); bin = opc(i); start = 1'b1;
            @(posedge clk); #1;
            if ((i % 6) == 4) begin
                r = ref_sub(opa(i - 4), opb(i - 4), opc(i - 4));
                pd_d = r[3:0]; pd_b = r[4];
            end
            if (done !== ((i % 6) == 4)) begin
                n_err++; $display("FAIL b2b_done@%0d: got %b, want %b", i, done, (i % 6) == 4);
            end
            n_cmp++;
            if (busy !== ((i % 6) != 5)) begin
                n_err++; $display("FAIL b2b_busy@%0d: got %b, want %b", i, busy, (i % 6) != 5);
            end
            n_cmp++;
            if (D !== pd_d || bout !== pd_b) begin
                n_err++; $display("FAIL b2b_result@%0d: got D=%h bout=%b, want D=%h bout=%b", i, D, bout, pd_d, pd_b);
            end
            n_cmp++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset_abort;
        logic [3:0] d; logic bo, pb, pd; int lat, bc;
        do_op(4'd9, 4'd3, 1'b0, d, bo, lat, bc, pb, pd);
        if (d !== 4'd6) begin
            n_err++; $display("FAIL abort_pre: got D=%h, want 6", d);
        end
        n_cmp++;
        @(negedge clk);
        A = 4'd12; B = 4'd1; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL abort_in_run: got busy=%b, want 1", busy);
        end
        n_cmp++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        if ({D, bout, busy, done} !== 7'd0) begin
            n_err++; $display("FAIL abort_async: got D=%h bout=%b busy=%b done=%b, want all 0", D, bout, busy, done);
        end
        n_cmp++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL abort_no_done@%0d: got done=%b busy=%b, want 0 0", i, done, busy);
            end
            n_cmp++;
        end
        do_op(4'd5, 4'd2, 1'b0, d, bo, lat, bc, pb, pd);
        if (d !== 4'd3 || bo !== 1'b0 || lat !== 5) begin
            n_err++; $display("FAIL abort_restart: got D=%h bout=%b lat=%0d, want D=3 bout=0 lat=5", d, bo, lat);
        end
        n_cmp++;
    endtask

    task automatic test_sweep;
        logic [3:0] d; logic bo, pb, pd; int lat, bc;
        logic [4:0] r;
        for (int i = 0; i < 512; i++) begin
            do_op(4'(i >> 5), 4'(i >> 1), 1'(i), d, bo, lat, bc, pb, pd);
            r = ref_sub(4'(i >> 5), 4'(i >> 1), 1'(i));
            if (d !== r[3:0] || bo !== r[4]) begin
                n_err++; $display("FAIL sweep A=%0d B=%0d bin=%0d: got D=%h bout=%b, want D=%h bout=%b",
                                  i >> 5, (i >> 1) & 15, i & 1, d, bo, r[3:0], r[4]);
            end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_back_to_back;
        test_reset_abort;
        test_sweep;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
